// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between CPU port C and debug port D; DMEM_ARB_RR_EN selects round-robin grant
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem2arb_req_i,
    input  logic        mem2arb_we_i,
    input  logic [1:0]  mem2arb_size_i,
    input  logic [31:0] mem2arb_addr_i,
    input  logic [31:0] mem2arb_wdata_i,
    output logic [31:0] arb2mem_rdata_o,
    output logic        arb2mem_ack_o,
    output logic        arb2mem_misalign_o,
    output logic        arb2mem_stall_o,
    input  logic        dbg2arb_req_i,
    input  logic        dbg2arb_we_i,
    input  logic [31:0] dbg2arb_addr_i,
    input  logic [31:0] dbg2arb_wdata_i,
    output logic [31:0] arb2dbg_rdata_o,
    output logic        arb2dbg_ack_o,
    output logic        arb2ram_en_o,
    output logic        arb2ram_we_o,
    output logic [3:0]  arb2ram_be_o,
    output logic [31:0] arb2ram_addr_o,
    output logic [31:0] arb2ram_wdata_o,
    input  logic [31:0] ram2arb_rdata_i
);
    typedef enum logic [2:0] {IDLE, ACC_C, RESP_C, ACC_D, RESP_D} state_t;
    state_t state, state_nx;
    logic        op_we, op_mis, grant_c, grant_d, c_mis, acc, c_load_done, d_load_done;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata, c_rdata_q, d_rdata_q, c_shift, lane_wdata;
    logic [3:0]  lane_be;
`ifdef DMEM_ARB_RR_EN
    logic last_d;
    assign grant_c = mem2arb_req_i && !(dbg2arb_req_i && !last_d);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_d <= 1'b1;
        else if (state == IDLE && (grant_c || grant_d))
            last_d <= grant_d;
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_CNT = WW'(MAX_WAIT);
    logic [WW-1:0] wait_cnt;
    assign grant_c = mem2arb_req_i && !(dbg2arb_req_i && wait_cnt == MAX_CNT);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= grant_d ? '0 : (dbg2arb_req_i && grant_c) ? wait_cnt + 1'b1 : wait_cnt;
`endif
    assign grant_d = dbg2arb_req_i && !grant_c;
    assign c_mis = mem2arb_size_i == 2'b11 || (mem2arb_size_i == 2'b01 && mem2arb_addr_i[0]) ||
                   (mem2arb_size_i == 2'b10 && mem2arb_addr_i[1:0] != 2'b00);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_c ? ACC_C : grant_d ? ACC_D : IDLE;
            ACC_C:   state_nx = RESP_C;
            ACC_D:   state_nx = RESP_D;
            default: state_nx = IDLE;
        endcase
    end
    assign lane_be = op_size == 2'b00 ? 4'b0001 << op_addr[1:0] :
                     op_size == 2'b01 ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign lane_wdata = op_size == 2'b00 ? {4{op_wdata[7:0]}} :
                        op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
    assign acc = (state == ACC_C && !op_mis) || state == ACC_D;
    assign arb2ram_en_o = acc;
    assign arb2ram_we_o = acc && op_we;
    assign arb2ram_be_o = acc ? lane_be : 4'b0000;
    assign arb2ram_addr_o = acc ? {op_addr[31:2], 2'b00} : 32'd0;
    assign arb2ram_wdata_o = acc ? lane_wdata : 32'd0;
    assign c_shift = ram2arb_rdata_i >> {op_addr[1:0], 3'b000};
    assign c_load_done = state == RESP_C && !op_we && !op_mis;
    assign d_load_done = state == RESP_D && !op_we;
    assign arb2mem_rdata_o = c_load_done ? c_shift : c_rdata_q;
    assign arb2dbg_rdata_o = d_load_done ? ram2arb_rdata_i : d_rdata_q;
    assign arb2mem_ack_o = state == RESP_C;
    assign arb2mem_misalign_o = state == RESP_C && op_mis;
    assign arb2dbg_ack_o = state == RESP_D;
    assign arb2mem_stall_o = mem2arb_req_i && !arb2mem_ack_o;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_mis    <= 1'b0;
            op_size   <= 2'b00;
            op_addr   <= 32'd0;
            op_wdata  <= 32'd0;
            c_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant_c) begin
                op_we    <= mem2arb_we_i;
                op_mis   <= c_mis;
                op_size  <= mem2arb_size_i;
                op_addr  <= mem2arb_addr_i;
                op_wdata <= mem2arb_wdata_i;
            end else if (state == IDLE && grant_d) begin
                op_we    <= dbg2arb_we_i;
                op_mis   <= 1'b0;
                op_size  <= 2'b10;
                op_addr  <= dbg2arb_addr_i;
                op_wdata <= dbg2arb_wdata_i;
            end
            if (c_load_done)
                c_rdata_q <= c_shift;
            if (d_load_done)
                d_rdata_q <= ram2arb_rdata_i;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a byte-enabled synchronous RAM model
module tb_dmem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        c_req = 0, c_we = 0, c_ack, c_mis, c_stall;
    logic [1:0]  c_size = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, c_rdata;
    logic        d_req = 0, d_we = 0, d_ack;
    logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [31:0] mem [256];
    int vecs = 0, errs = 0;
    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;
    exp_t sb [$];
    logic exp_port [$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .mem2arb_req_i(c_req), .mem2arb_we_i(c_we), .mem2arb_size_i(c_size),
        .mem2arb_addr_i(c_addr), .mem2arb_wdata_i(c_wdata),
        .arb2mem_rdata_o(c_rdata), .arb2mem_ack_o(c_ack),
        .arb2mem_misalign_o(c_mis), .arb2mem_stall_o(c_stall),
        .dbg2arb_req_i(d_req), .dbg2arb_we_i(d_we), .dbg2arb_addr_i(d_addr),
        .dbg2arb_wdata_i(d_wdata), .arb2dbg_rdata_o(d_rdata), .arb2dbg_ack_o(d_ack),
        .arb2ram_en_o(ram_en), .arb2ram_we_o(ram_we), .arb2ram_be_o(ram_be),
        .arb2ram_addr_o(ram_addr), .arb2ram_wdata_o(ram_wdata),
        .ram2arb_rdata_i(ram_rdata)
    );

    always @(posedge clk)
        if (ram_en) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_be[b])
                        mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[9:2]];
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [1:0] size, input logic [31:0] addr, wdata,
                          input logic exp_mis, input logic [3:0] exp_be, input logic [31:0] exp_wd, exp_rdata);
        exp_t e, got;
        int n = 0;
        logic acked = 0, stall_ok = 1, en_seen = 0, we_seen = 0;
        logic [3:0] be_seen = 0;
        logic [31:0] wd_seen = 0, ad_seen = 0;
        e.rdata = exp_rdata; e.mis = exp_mis; e.be = exp_be; e.wdata = exp_wd;
        e.addr = {addr[31:2], 2'b00};
        sb.push_back(e);
        @(posedge clk); #1;
        c_req = 1; c_we = we; c_size = size; c_addr = addr; c_wdata = wdata;
        while (!acked && n < 8) begin
            @(negedge clk);
            n++;
            if (ram_en) begin
                en_seen = 1; we_seen = ram_we; be_seen = ram_be; wd_seen = ram_wdata; ad_seen = ram_addr;
            end
            if (c_ack) acked = 1;
            else if (!c_stall) stall_ok = 0;
        end
        got = sb.pop_front();
        chk("cpu_ack", acked, 1);
        chk("cpu_latency", n, 3);
        chk("cpu_misalign", c_mis, got.mis);
        chk("cpu_rdata", c_rdata, got.rdata);
        chk("cpu_stall_at_ack", c_stall, 0);
        chk("cpu_stall_wait", stall_ok, 1);
        chk("cpu_ram_en", en_seen, !got.mis);
        if (!got.mis) begin
            chk("cpu_ram_we", we_seen, we);
            chk("cpu_ram_be", be_seen, got.be);
            chk("cpu_ram_addr", ad_seen, got.addr);
            if (we) chk("cpu_ram_wdata", wd_seen, got.wdata);
        end
        @(posedge clk); #1;
        c_req = 0;
    endtask

    task automatic dbg_op(input logic we, input logic [31:0] addr, wdata, exp_addr, exp_rdata);
        int n = 0;
        logic acked = 0, en_seen = 0;
        logic [3:0] be_seen = 0;
        logic [31:0] ad_seen = 0, wd_seen = 0;
        exp_t e, got;
        e.rdata = exp_rdata; e.mis = 0; e.be = 4'hF; e.wdata = wdata; e.addr = exp_addr;
        sb.push_back(e);
        @(posedge clk); #1;
        d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        while (!acked && n < 8) begin
            @(negedge clk);
            n++;
            if (ram_en) begin
                en_seen = 1; be_seen = ram_be; ad_seen = ram_addr; wd_seen = ram_wdata;
            end
            if (d_ack) acked = 1;
        end
        got = sb.pop_front();
        chk("dbg_ack", acked, 1);
        chk("dbg_latency", n, 3);
        chk("dbg_ram_en", en_seen, 1);
        chk("dbg_ram_be", be_seen, got.be);
        chk("dbg_ram_addr", ad_seen, got.addr);
        if (we) chk("dbg_ram_wdata", wd_seen, got.wdata);
        chk("dbg_rdata", d_rdata, got.rdata);
        @(posedge clk); #1;
        d_req = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_c_ack", c_ack, 0);
        chk("rst_c_mis", c_mis, 0);
        chk("rst_c_stall", c_stall, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_be", ram_be, 0);
        @(posedge clk); #1;
        rst = 0;

        cpu_op(1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
        cpu_op(0, 2'b10, 32'h10, 32'h0,        0, 4'b1111, 32'h0,        32'hDEADBEEF);
        cpu_op(1, 2'b00, 32'h13, 32'h000000A5, 0, 4'b1000, 32'hA5A5A5A5, 32'hDEADBEEF);
        cpu_op(0, 2'b00, 32'h13, 32'h0,        0, 4'b1000, 32'h0,        32'h000000A5);
        cpu_op(0, 2'b00, 32'h11, 32'h0,        0, 4'b0010, 32'h0,        32'h00A5ADBE);
        cpu_op(1, 2'b01, 32'h16, 32'h1234CAFE, 0, 4'b1100, 32'hCAFECAFE, 32'h00A5ADBE);
        cpu_op(0, 2'b01, 32'h16, 32'h0,        0, 4'b1100, 32'h0,        32'h0000CAFE);
        cpu_op(1, 2'b10, 32'h20, 32'h55667788, 0, 4'b1111, 32'h55667788, 32'h0000CAFE);
        cpu_op(1, 2'b01, 32'h23, 32'h0000FFFF, 1, 4'b0000, 32'h0,        32'h0000CAFE);
        cpu_op(0, 2'b01, 32'h21, 32'h0,        1, 4'b0000, 32'h0,        32'h0000CAFE);
        cpu_op(0, 2'b10, 32'h22, 32'h0,        1, 4'b0000, 32'h0,        32'h0000CAFE);
        cpu_op(0, 2'b11, 32'h20, 32'h0,        1, 4'b0000, 32'h0,        32'h0000CAFE);
        cpu_op(0, 2'b10, 32'h20, 32'h0,        0, 4'b1111, 32'h0,        32'h55667788);
        cpu_op(0, 2'b01, 32'h12, 32'h0,        0, 4'b1100, 32'h0,        32'h0000A5AD);

        dbg_op(1, 32'h43, 32'h12345678, 32'h40, 32'h0);
        cpu_op(0, 2'b10, 32'h40, 32'h0,        0, 4'b1111, 32'h0,        32'h12345678);
        dbg_op(0, 32'h40, 32'h0,        32'h40, 32'h12345678);

`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 10; i++) exp_port.push_back(i % 2 == 1);
`else
        for (int i = 0; i < 10; i++) exp_port.push_back(i % 5 == 4);
`endif
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_size = 2'b10; c_addr = 32'h10;
        d_req = 1; d_we = 0; d_addr = 32'h40;
        for (int n = 0; n < 100 && exp_port.size() > 0; n++) begin
            @(negedge clk);
            if (c_ack || d_ack) chk("grant_order", d_ack, exp_port.pop_front());
        end
        chk("grant_remaining", exp_port.size(), 0);
        @(posedge clk); #1;
        c_req = 0; d_req = 0;

        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_size = 2'b10; c_addr = 32'h50; c_wdata = 32'h11111111;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ram_en", ram_en, 1);
        rst = 1; c_req = 0;
        #1;
        chk("mid_rst_ram_en", ram_en, 0);
        chk("mid_rst_c_ack", c_ack, 0);
        @(negedge clk);
        chk("post_rst_ram_en", ram_en, 0);
        chk("post_rst_c_ack", c_ack, 0);
        chk("post_rst_c_rdata", c_rdata, 0);
        @(posedge clk); #1;
        rst = 0;
        cpu_op(0, 2'b10, 32'h10, 32'h0, 0, 4'b1111, 32'h0, 32'hA5ADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
